// File: rtl/spi_slave_to_wb_pkg.sv
// spi_slave_to_wb shared types.
// Frame/WB state encodings and bus request bundle.
package spi_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DUMMY,
    RD_DATA
  } frame_state_e;

  typedef enum logic {
    WB_IDLE,
    WB_REQ
  } wb_state_e;

  localparam int         CMD_WRITE_BIT = 7;
  localparam logic [7:0] FILL_BYTE     = 8'hFF;

  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } wb_req_t;

endpackage

// File: rtl/spi_slave_to_wb_if.sv
// 8-bit Wishbone register bus between the
// SPI bridge (master) and the local register map (slave).
interface spi_slave_to_wb_if;

  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o,
    output wb_dat_o,
    output wb_we_o,
    output wb_cyc_o,
    output wb_stb_o,
    input  wb_dat_i,
    input  wb_ack_i
  );

  modport slave (
    input  wb_adr_o,
    input  wb_dat_o,
    input  wb_we_o,
    input  wb_cyc_o,
    input  wb_stb_o,
    output wb_dat_i,
    output wb_ack_i
  );

endinterface

// File: rtl/spi_slave_to_wb_shift.sv
// SPI mode-0 front end: pin synchronisers, edge
// detect, bit counter and RX/TX shift registers.
module spi_slave_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_ni,
  input  logic       mosi_i,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       miso_o,
  output logic       cs_active,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_q, cs_q;
  logic                   sck_rise, sck_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_sh;
  logic [7:0]             tx_sh;

  // chip select idles high so a held reset never
  // looks like a selected frame
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_ni};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign cs_active = ~cs_s;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh   <= {rx_sh[6:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_byte   <= {rx_sh[6:0], mosi_s};
        end
      end
    end
  end

  // the fall that closes a byte (count back at 0)
  // must not shift out the freshly loaded MSB
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tx_sh <= '0;
    end else if (tx_load) begin
      tx_sh <= tx_data;
    end else if (sck_fall && !cs_s && bit_cnt != 3'd0) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

  assign miso_o = tx_sh[7];

endmodule

// File: rtl/spi_slave_to_wb.sv
// SPI mode-0 slave decoding byte commands into
// 8-bit Wishbone master cycles.
module spi_slave_to_wb
  import spi_wb_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic cs_ni,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe,
  output logic busy_o,
  output logic err_o,
  spi_slave_to_wb_if.master wb
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic         cs_active, cs_fall, cs_rise;
  logic         byte_done, tx_load;
  logic [7:0]   rx_byte, tx_data;
  frame_state_e state_q, state_d;
  wb_state_e    wb_state_q, wb_state_d;
  logic [1:0]   addr_q, addr_d;
  logic         issue, err_clr, err_q;
  logic         tmo_hit, overrun;
  wb_req_t      issue_req, req_q;
  logic [7:0]   fetched_q;
  logic [TW-1:0] tmo_q;

  spi_slave_shift #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shift (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sck_i    (sck_i),
    .cs_ni    (cs_ni),
    .mosi_i   (mosi_i),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .miso_o   (miso_o),
    .cs_active(cs_active),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .byte_done(byte_done),
    .rx_byte  (rx_byte)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // a byte completing alongside CS rise is still
  // issued; the CS rise only redirects the state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cs_fall) state_d = CMD;
      CMD:      if (byte_done)
                  state_d = rx_byte[CMD_WRITE_BIT] ?
                            WR_DATA : RD_DUMMY;
      WR_DATA:  state_d = WR_DATA;
      RD_DUMMY: if (byte_done) state_d = RD_DATA;
      RD_DATA:  state_d = RD_DATA;
      default:  state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_comb begin
    issue     = 1'b0;
    issue_req = '0;
    tx_load   = 1'b0;
    tx_data   = 8'h00;
    addr_d    = addr_q;
    err_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_load = 1'b1;
          err_clr = 1'b1;
        end
      end
      CMD: begin
        if (byte_done) begin
          addr_d = rx_byte[1:0];
          if (!rx_byte[CMD_WRITE_BIT]) begin
            issue     = 1'b1;
            issue_req = '{we: 1'b0, adr: rx_byte[1:0],
                          dat: 8'h00};
          end
        end
      end
      WR_DATA: begin
        if (byte_done) begin
          issue     = 1'b1;
          issue_req = '{we: 1'b1, adr: addr_q,
                        dat: rx_byte};
          addr_d    = addr_q + 2'd1;
        end
      end
      RD_DUMMY, RD_DATA: begin
        if (byte_done) begin
          tx_load   = 1'b1;
          tx_data   = fetched_q;
          addr_d    = addr_q + 2'd1;
          issue     = 1'b1;
          issue_req = '{we: 1'b0, adr: addr_q + 2'd1,
                        dat: 8'h00};
        end
      end
      default: ;
    endcase
  end

  assign tmo_hit = (wb_state_q == WB_REQ) && !wb.wb_ack_i &&
                   (tmo_q == TW'(TIMEOUT - 1));
  assign overrun = issue && (wb_state_q == WB_REQ);

  always_ff @(posedge clk_i) begin
    if (!rst_i) wb_state_q <= WB_IDLE;
    else        wb_state_q <= wb_state_d;
  end

  always_comb begin
    wb_state_d = wb_state_q;
    unique case (wb_state_q)
      WB_IDLE: if (issue) wb_state_d = WB_REQ;
      WB_REQ:  if (wb.wb_ack_i || tmo_hit)
                 wb_state_d = WB_IDLE;
      default: wb_state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    wb.wb_cyc_o = (wb_state_q == WB_REQ);
    wb.wb_stb_o = (wb_state_q == WB_REQ);
    wb.wb_we_o  = req_q.we;
    wb.wb_adr_o = req_q.adr;
    wb.wb_dat_o = req_q.dat;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_q     <= '0;
      tmo_q     <= '0;
      fetched_q <= '0;
    end else begin
      if (wb_state_q == WB_IDLE && issue) begin
        req_q <= issue_req;
        tmo_q <= '0;
      end else if (wb_state_q == WB_REQ) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (wb_state_q == WB_REQ && wb.wb_ack_i && !req_q.we)
        fetched_q <= wb.wb_dat_i;
      else if (tmo_hit)
        fetched_q <= FILL_BYTE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)                  err_q <= 1'b0;
    else if (err_clr)            err_q <= 1'b0;
    else if (tmo_hit || overrun) err_q <= 1'b1;
  end

  assign err_o   = err_q;
  assign miso_oe = cs_active;
  assign busy_o  = (state_q != IDLE) || (wb_state_q == WB_REQ);

endmodule

// File: tb/tb_spi_slave_to_wb.sv
// Bench for spi_slave_to_wb: SPI master driver,
// Wishbone register-file responder, memory reference model.
module tb_spi_slave_to_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic sck   = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic miso, miso_oe, busy, err;

  spi_slave_to_wb_if wb();

  spi_slave_to_wb #(
    .TIMEOUT    (64),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .sck_i  (sck),
    .cs_ni  (cs_n),
    .mosi_i (mosi),
    .miso_o (miso),
    .miso_oe(miso_oe),
    .busy_o (busy),
    .err_o  (err),
    .wb     (wb)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Wishbone register-file responder
  typedef struct packed {
    logic [1:0] adr;
    logic [7:0] dat;
  } wr_t;

  logic [7:0] mem [4];
  wr_t        wr_q [$];
  int         ack_dly = 1;
  int         wcnt = 0;

  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = 8'h00;
    forever begin
      @(negedge clk);
      if (wb.wb_ack_i) begin
        wb.wb_ack_i = 1'b0;
      end else if (wb.wb_cyc_o && wb.wb_stb_o) begin
        if (ack_dly >= 0 && wcnt >= ack_dly) begin
          wb.wb_ack_i = 1'b1;
          wb.wb_dat_i = mem[wb.wb_adr_o];
          if (wb.wb_we_o) begin
            mem[wb.wb_adr_o] = wb.wb_dat_o;
            wr_q.push_back('{adr: wb.wb_adr_o,
                             dat: wb.wb_dat_o});
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // cycle counter and cyc-high run length
  int   ncyc = 0;
  int   run = 0;
  int   last_run = 0;
  logic cyc_p = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (wb.wb_cyc_o && !cyc_p) ncyc++;
      if (wb.wb_cyc_o) begin
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      cyc_p = wb.wb_cyc_o;
    end
  end

  // SPI master driver, mode 0, all activity on negedge
  int half = 4;
  int gap  = 8;

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx,
                          input int nb,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = tx[i];
      clk_n(half);
      rx[i] = miso;
      sck = 1'b1;
      clk_n(half);
      sck = 1'b0;
    end
    clk_n(gap);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    clk_n(8);
  endtask

  task automatic cs_end();
    clk_n(half);
    cs_n = 1'b1;
    clk_n(8);
  endtask

  task automatic wait_idle(input string name,
                           input int budget);
    int n = 0;
    while (busy && n < budget) begin
      clk_n(1);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  typedef struct packed {
    logic [3:0][7:0] tx;
    logic [2:0]      n;
    logic [3:0][7:0] rx;
    logic [1:0]      nw;
    logic [1:0][1:0] wa;
    logic [1:0][7:0] wd;
  } vec_t;

  vec_t       vt [5];
  logic [7:0] rx;
  logic [7:0] ref_mem [4];
  logic [1:0] ea [$];
  logic [7:0] ed [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vt[0] = '{tx: 32'h0000_0002, n: 3'd4,
              rx: 32'h3CA5_0000, nw: 2'd0,
              wa: 4'h0, wd: 16'h0000};
    vt[1] = '{tx: 32'h0000_5A81, n: 3'd2,
              rx: 32'h0, nw: 2'd1,
              wa: 4'b0001, wd: 16'h005A};
    vt[2] = '{tx: 32'h0022_1183, n: 3'd3,
              rx: 32'h0, nw: 2'd2,
              wa: 4'b0011, wd: 16'h2211};
    vt[3] = '{tx: 32'h0044_99FE, n: 3'd3,
              rx: 32'h0, nw: 2'd2,
              wa: 4'b1110, wd: 16'h4499};
    vt[4] = '{tx: 32'h0000_007D, n: 3'd4,
              rx: 32'h995A_0000, nw: 2'd0,
              wa: 4'h0, wd: 16'h0000};
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    mem[2] = 8'hA5;
    mem[3] = 8'h3C;

    clk_n(3);
    check("reset_outputs",
          {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o,
           wb.wb_adr_o, wb.wb_dat_o, miso, miso_oe,
           busy, err}, 32'h0);
    rst_n = 1'b1;
    clk_n(4);

    for (int v = 0; v < 5; v++) begin
      wr_q.delete();
      ack_dly = 1;
      cs_start();
      check($sformatf("v%0d_oe_on", v), miso_oe, 1'b1);
      for (int b = 0; b < int'(vt[v].n); b++) begin
        spi_bits(vt[v].tx[b], 8, rx);
        check($sformatf("v%0d_miso_b%0d", v, b),
              rx, vt[v].rx[b]);
      end
      cs_end();
      check($sformatf("v%0d_oe_off", v), miso_oe, 1'b0);
      wait_idle($sformatf("v%0d_busy", v), 100);
      check($sformatf("v%0d_nwr", v),
            wr_q.size(), vt[v].nw);
      for (int w = 0; w < int'(vt[v].nw); w++) begin
        if (w < wr_q.size()) begin
          check($sformatf("v%0d_wadr%0d", v, w),
                wr_q[w].adr, vt[v].wa[w]);
          check($sformatf("v%0d_wdat%0d", v, w),
                wr_q[w].dat, vt[v].wd[w]);
        end
      end
      check($sformatf("v%0d_err", v), err, 1'b0);
    end

    // read with a slave that never acks
    begin
      int n = 0;
      ack_dly = -1;
      cs_start();
      spi_bits(8'h00, 8, rx);
      while (wb.wb_cyc_o && n < 200) begin
        clk_n(1);
        n++;
      end
      clk_n(2);
      check("tmo_cyc_len", last_run, 64);
      check("tmo_err_set", err, 1'b1);
      spi_bits(8'h00, 8, rx);
      check("tmo_dummy", rx, 8'h00);
      spi_bits(8'h00, 8, rx);
      check("tmo_fill", rx, 8'hFF);
      cs_end();
      wait_idle("tmo_busy", 300);
      check("tmo_err_sticky", err, 1'b1);
      cs_n = 1'b0;
      clk_n(8);
      check("tmo_err_clear", err, 1'b0);
      cs_n = 1'b1;
      clk_n(8);
    end

    // slow ack, bytes arriving faster than the bus
    begin
      int c0;
      ack_dly = 60;
      half = 2;
      gap = 2;
      wr_q.delete();
      c0 = ncyc;
      cs_start();
      spi_bits(8'h80, 8, rx);
      spi_bits(8'h01, 8, rx);
      spi_bits(8'h02, 8, rx);
      cs_end();
      half = 4;
      gap = 8;
      wait_idle("ovr_busy", 300);
      check("ovr_nwr", wr_q.size(), 1);
      if (wr_q.size() > 0)
        check("ovr_wr0", wr_q[0], {2'd0, 8'h01});
      check("ovr_err", err, 1'b1);
      check("ovr_ncyc", ncyc - c0, 1);
    end

    // partial byte, then reset during a bus cycle
    begin
      int n = 0;
      ack_dly = 1;
      wr_q.delete();
      cs_start();
      spi_bits(8'h80, 8, rx);
      spi_bits(8'hF0, 4, rx);
      cs_end();
      wait_idle("part_busy", 100);
      check("part_nwr", wr_q.size(), 0);
      ack_dly = -1;
      cs_start();
      spi_bits(8'h81, 8, rx);
      spi_bits(8'h77, 8, rx);
      while (!wb.wb_cyc_o && n < 50) begin
        clk_n(1);
        n++;
      end
      check("rst_cyc_up", wb.wb_cyc_o, 1'b1);
      clk_n(5);
      rst_n = 1'b0;
      clk_n(1);
      check("rst_mid_cycle",
            {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o,
             wb.wb_adr_o, wb.wb_dat_o, miso, miso_oe,
             busy, err}, 32'h0);
      cs_n = 1'b1;
      clk_n(3);
      rst_n = 1'b1;
      clk_n(4);
      check("rst_nwr", wr_q.size(), 0);
    end

    // random frames against a register-file model
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int f = 0; f < 12; f++) begin
      logic       rd;
      logic [1:0] a, ak;
      int         nb;
      logic [7:0] d;
      rd = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 3);
      ack_dly = $urandom_range(1, 4);
      wr_q.delete();
      ea.delete();
      ed.delete();
      cs_start();
      spi_bits({~rd, 5'($urandom), a}, 8, rx);
      check($sformatf("r%0d_cmd_miso", f), rx, 8'h00);
      if (rd) begin
        spi_bits(8'($urandom), 8, rx);
        check($sformatf("r%0d_dummy", f), rx, 8'h00);
      end
      for (int k = 0; k < nb; k++) begin
        ak = a + 2'(k);
        d  = 8'($urandom);
        spi_bits(d, 8, rx);
        if (rd) begin
          check($sformatf("r%0d_rd%0d", f, k),
                rx, ref_mem[ak]);
        end else begin
          ea.push_back(ak);
          ed.push_back(d);
          ref_mem[ak] = d;
        end
      end
      cs_end();
      wait_idle($sformatf("r%0d_busy", f), 200);
      check($sformatf("r%0d_nwr", f),
            wr_q.size(), ea.size());
      for (int k = 0; k < ea.size(); k++) begin
        if (k < wr_q.size())
          check($sformatf("r%0d_wr%0d", f, k),
                wr_q[k], {ea[k], ed[k]});
      end
      check($sformatf("r%0d_err", f), err, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
